// File: rtl/erbium_pkg.sv
// Shared constants and types for the erbium result path.
package erbium_pkg;

    localparam int C_RESULT_WIDTH = 32;

    typedef logic [C_RESULT_WIDTH-1:0] result_word_t;

    localparam result_word_t C_PAD_WORD = {C_RESULT_WIDTH{1'b1}};

endpackage

// File: rtl/erbium_packer_stats.sv
// Accepted-word and consumed-beat counters for the result packer; both wrap modulo 2^32.
module erbium_packer_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        word_acc_i,
    input  logic        beat_take_i,
    output logic [31:0] result_cnt_o,
    output logic [31:0] beat_cnt_o
);

    logic [31:0] result_cnt_r;
    logic [31:0] beat_cnt_r;

    // Free-running event counters, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_cnt_r <= 32'd0;
            beat_cnt_r   <= 32'd0;
        end else begin
            if (word_acc_i) begin
                result_cnt_r <= result_cnt_r + 32'd1;
            end
            if (beat_take_i) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
            end
        end
    end

    assign result_cnt_o = result_cnt_r;
    assign beat_cnt_o   = beat_cnt_r;

endmodule

// File: rtl/erbium_result_packer.sv
// Packs narrow engine result words into full-width write beats, padding partial beats with all-ones.
// Statistics counters are built only when ERBIUM_PACKER_STATS_EN is defined.
module erbium_result_packer
    import erbium_pkg::*;
#(
    parameter int G_DATA_BUS_WIDTH = 512,
    parameter int G_RESULT_WIDTH   = C_RESULT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [G_RESULT_WIDTH-1:0]   res_data_i,
    input  logic                        res_valid_i,
    input  logic                        res_last_i,
    output logic                        res_ready_o,
    output logic [G_DATA_BUS_WIDTH-1:0] wr_data_o,
    output logic                        wr_valid_o,
    output logic                        wr_last_o,
    input  logic                        wr_ready_i,
    output logic [31:0]                 result_cnt_o,
    output logic [31:0]                 beat_cnt_o
);

    localparam int N     = G_DATA_BUS_WIDTH / G_RESULT_WIDTH;
    localparam int IDX_W = $clog2(N);

    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(N - 1);
    localparam logic [G_RESULT_WIDTH-1:0] PAD_WORD = {G_RESULT_WIDTH{1'b1}};

    logic [N-2:0][G_RESULT_WIDTH-1:0] acc_r;
    logic [IDX_W-1:0]                 idx_r;
    logic [N-1:0][G_RESULT_WIDTH-1:0] beat_s;
    logic [G_DATA_BUS_WIDTH-1:0]      wr_data_r;
    logic                             wr_valid_r;
    logic                             wr_last_r;
    logic                             ready_s;
    logic                             word_acc_s;
    logic                             beat_take_s;
    logic                             close_s;

    assign ready_s     = ~wr_valid_r | wr_ready_i;
    assign word_acc_s  = res_valid_i & ready_s;
    assign beat_take_s = wr_valid_r & wr_ready_i;
    assign close_s     = res_last_i | (idx_r == IDX_LAST);

    // Candidate beat: stored lanes below the index, the incoming word at it, pad above it.
    always_comb begin
        beat_s = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (IDX_W'(k) < idx_r) begin
                beat_s[k] = acc_r[k];
            end else if (IDX_W'(k) == idx_r) begin
                beat_s[k] = res_data_i;
            end else begin
                beat_s[k] = PAD_WORD;
            end
        end
        if (idx_r == IDX_LAST) begin
            beat_s[N-1] = res_data_i;
        end else begin
            beat_s[N-1] = PAD_WORD;
        end
    end

    // Accumulator, lane index and output beat register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_r      <= '0;
            idx_r      <= '0;
            wr_data_r  <= '0;
            wr_valid_r <= 1'b0;
            wr_last_r  <= 1'b0;
        end else begin
            if (beat_take_s) begin
                wr_valid_r <= 1'b0;
            end
            // A closing word overrides the consume so the register reloads at full rate.
            if (word_acc_s) begin
                if (close_s) begin
                    wr_data_r  <= beat_s;
                    wr_last_r  <= res_last_i;
                    wr_valid_r <= 1'b1;
                    idx_r      <= '0;
                end else begin
                    acc_r[idx_r] <= res_data_i;
                    idx_r        <= idx_r + IDX_ONE;
                end
            end
        end
    end

    assign res_ready_o = ready_s;
    assign wr_data_o   = wr_data_r;
    assign wr_valid_o  = wr_valid_r;
    assign wr_last_o   = wr_last_r;

`ifdef ERBIUM_PACKER_STATS_EN
    erbium_packer_stats u_stats (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .word_acc_i   (word_acc_s),
        .beat_take_i  (beat_take_s),
        .result_cnt_o (result_cnt_o),
        .beat_cnt_o   (beat_cnt_o)
    );
`else
    assign result_cnt_o = 32'd0;
    assign beat_cnt_o   = 32'd0;
`endif

endmodule
